// File: rtl/seg7_jtag_dbg_pkg.sv
// Shared types and constants for the JTAG on-chip-memory debug controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, bit positions inside the 38-bit jdo word.
package seg7_jtag_dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_JRD,
        ST_JCAP,
        ST_JWR,
        ST_CRD
    } ocimem_state_t;

    localparam int JDO_W       = 38;
    localparam int JDO_RDREQ   = 35;
    localparam int JDO_DATA_HI = 34;
    localparam int JDO_DATA_LO = 3;
    localparam int JDO_ADDR_LO = 17;

endpackage

// File: rtl/seg7_jtag_ocimem_ctrl_if.sv
// Bundle of the JTAG strobe/data path and the CPU slave port of the debug controller.
// Latency: n/a (wires only).
// Backpressure: cpu_waitrequest stalls the CPU side; JTAG side has none (status via monitor_ready).
// Modports: slave = controller side, master = JTAG stage + CPU driver side.
interface seg7_jtag_ocimem_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic [37:0]       jdo;
    logic              take_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic              take_no_action_ocimem_a;
    logic [31:0]       MonDReg;
    logic              monitor_ready;
    logic              monitor_error;
    logic [ADDR_W-1:0] cpu_address;
    logic              cpu_read;
    logic              cpu_write;
    logic [31:0]       cpu_writedata;
    logic [31:0]       cpu_readdata;
    logic              cpu_readdatavalid;
    logic              cpu_waitrequest;

    modport slave (
        input  jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
        input  cpu_address, cpu_read, cpu_write, cpu_writedata,
        output MonDReg, monitor_ready, monitor_error,
        output cpu_readdata, cpu_readdatavalid, cpu_waitrequest
    );

    modport master (
        output jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
        output cpu_address, cpu_read, cpu_write, cpu_writedata,
        input  MonDReg, monitor_ready, monitor_error,
        input  cpu_readdata, cpu_readdatavalid, cpu_waitrequest
    );

endinterface

// File: rtl/seg7_jtag_ocimem_ram.sv
// Single-port 2**ADDR_W x 32 debug RAM, synchronous read.
// Latency: q valid 1 cycle after address; read-during-write returns the old word.
// Backpressure: none, accepts an access every cycle.
// Ports: clk, address, wren, data (write word), q (read word). Contents are not reset.
module seg7_jtag_ocimem_ram #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] address,
    input  logic              wren,
    input  logic [31:0]       data,
    output logic [31:0]       q
);

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (wren) begin
            mem[address] <= data;
        end
        q <= mem[address];
    end

endmodule

// File: rtl/seg7_jtag_ocimem_ctrl.sv
// JTAG debug access to on-chip debug RAM with a lower-priority CPU slave port.
// Latency: JTAG read 2 cycles (ready low), JTAG write 1 cycle, CPU read 2 cycles, CPU write 0 stall.
// Backpressure: cpu_waitrequest while busy or a JTAG strobe is present; JTAG strobes while busy are dropped and flagged.
// Ports: clk, reset (async, active high), bus (slave modport: jdo + strobes in, MonDReg/monitor_* out, CPU port).
module seg7_jtag_ocimem_ctrl
    import seg7_jtag_dbg_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int ROM_WORDS = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    seg7_jtag_ocimem_ctrl_if.slave  bus
);

    localparam logic [31:0] ROM_LIMIT = 32'(ROM_WORDS);

    ocimem_state_t     state;
    logic [ADDR_W-1:0] jaddr;
    logic [31:0]       mon_dreg;
    logic              mon_ready;
    logic              mon_error;
    logic [31:0]       cpu_rdata;
    logic              cpu_rvld;

    logic              strobe_any;
    logic              idle;
    logic [ADDR_W-1:0] jdo_addr;
    logic [31:0]       jdo_data;
    logic              rom_hit;
    logic              cpu_wr_go;
    logic              jtag_wr_go;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_q;
    logic              unused_jdo;

    assign strobe_any = bus.take_action_ocimem_a | bus.take_action_ocimem_b |
                        bus.take_no_action_ocimem_a;
    assign idle       = (state == ST_IDLE);
    assign jdo_addr   = bus.jdo[JDO_ADDR_LO+ADDR_W-1:JDO_ADDR_LO];
    assign jdo_data   = bus.jdo[JDO_DATA_HI:JDO_DATA_LO];
    assign unused_jdo = ^{bus.jdo[37:36], bus.jdo[2:0]};

    assign rom_hit    = (32'(jaddr) < ROM_LIMIT);

    // CPU write lands in the same IDLE cycle it is presented, unless JTAG claims the cycle.
    assign cpu_wr_go  = idle & ~strobe_any & bus.cpu_write & ~bus.cpu_read;
    assign jtag_wr_go = (state == ST_JWR) & ~rom_hit;

    // In IDLE the RAM address follows the CPU so an accepted read has q ready in CRD.
    assign ram_addr   = idle ? bus.cpu_address : jaddr;
    assign ram_wdata  = (state == ST_JWR) ? jdo_data : bus.cpu_writedata;
    assign ram_we     = (cpu_wr_go | jtag_wr_go) & ~reset;

    seg7_jtag_ocimem_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .address (ram_addr),
        .wren    (ram_we),
        .data    (ram_wdata),
        .q       (ram_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            jaddr     <= '0;
            mon_dreg  <= '0;
            mon_ready <= 1'b1;
            mon_error <= 1'b0;
            cpu_rdata <= '0;
            cpu_rvld  <= 1'b0;
        end else begin
            cpu_rvld <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.take_action_ocimem_a) begin
                        jaddr     <= jdo_addr;
                        // A coincident ocimem_b is a collision and must not be cleared away.
                        mon_error <= bus.take_action_ocimem_b;
                        if (bus.jdo[JDO_RDREQ]) begin
                            state     <= ST_JRD;
                            mon_ready <= 1'b0;
                        end
                    end else if (bus.take_action_ocimem_b) begin
                        state     <= ST_JWR;
                        mon_ready <= 1'b0;
                    end else if (bus.take_no_action_ocimem_a) begin
                        state     <= ST_JRD;
                        mon_ready <= 1'b0;
                    end else if (bus.cpu_read) begin
                        state <= ST_CRD;
                    end
                end
                ST_JRD: begin
                    state <= ST_JCAP;
                end
                ST_JCAP: begin
                    mon_dreg  <= ram_q;
                    jaddr     <= jaddr + 1'b1;
                    mon_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                ST_JWR: begin
                    if (rom_hit) begin
                        mon_error <= 1'b1;
                    end else begin
                        mon_dreg <= jdo_data;
                    end
                    jaddr     <= jaddr + 1'b1;
                    mon_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                ST_CRD: begin
                    cpu_rdata <= ram_q;
                    cpu_rvld  <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // Strobes arriving mid-operation are dropped; only the sticky flag records them.
            if (!idle && strobe_any) begin
                mon_error <= 1'b1;
            end
        end
    end

    assign bus.MonDReg           = mon_dreg;
    assign bus.monitor_ready     = mon_ready;
    assign bus.monitor_error     = mon_error;
    assign bus.cpu_readdata      = cpu_rdata;
    assign bus.cpu_readdatavalid = cpu_rvld;
    assign bus.cpu_waitrequest   = ~idle | strobe_any;

endmodule

// File: tb/tb_seg7_jtag_ocimem_ctrl.sv
// Self-checking bench for seg7_jtag_ocimem_ctrl: directed scenarios then randomized operations.
// Latency: n/a.
// Backpressure: n/a.
module tb_seg7_jtag_ocimem_ctrl;

    localparam int ADDR_W    = 8;
    localparam int DEPTH     = 256;
    localparam int ROM_WORDS = 32;

    logic clk = 1'b0;
    logic reset;

    seg7_jtag_ocimem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    seg7_jtag_ocimem_ctrl #(.ADDR_W(ADDR_W), .ROM_WORDS(ROM_WORDS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: debugger-visible state as plain variables.
    logic [31:0] m_mem [DEPTH];
    int          m_jaddr;
    logic [31:0] m_mon;
    logic        m_err;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] rand_jdo();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[37:0];
    endfunction

    task automatic wait_ready(output int lo);
        lo = 0;
        while (bus.monitor_ready !== 1'b1 && lo < 16) begin
            lo++;
            tick();
        end
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "_mon"}, bus.MonDReg, m_mon);
        check_eq({tag, "_err"}, {31'b0, bus.monitor_error}, {31'b0, m_err});
    endtask

    task automatic jtag_load(input logic [7:0] addr, input logic rd, input logic with_b);
        logic [37:0] j;
        int lo;
        j = rand_jdo();
        j[35] = rd;
        j[24:17] = addr;
        bus.jdo = j;
        bus.take_action_ocimem_a = 1'b1;
        bus.take_action_ocimem_b = with_b;
        tick();
        bus.take_action_ocimem_a = 1'b0;
        bus.take_action_ocimem_b = 1'b0;
        wait_ready(lo);
        m_jaddr = int'(addr);
        m_err   = with_b;
        if (rd) begin
            m_mon   = m_mem[m_jaddr];
            m_jaddr = (m_jaddr + 1) % DEPTH;
        end
        check_eq("load_busy", lo, rd ? 2 : 0);
        check_state("load");
    endtask

    task automatic jtag_write(input logic [31:0] data);
        logic [37:0] j;
        int lo;
        j = rand_jdo();
        j[34:3] = data;
        bus.jdo = j;
        bus.take_action_ocimem_b = 1'b1;
        tick();
        bus.take_action_ocimem_b = 1'b0;
        wait_ready(lo);
        if (m_jaddr < ROM_WORDS) begin
            m_err = 1'b1;
        end else begin
            m_mem[m_jaddr] = data;
            m_mon = data;
        end
        m_jaddr = (m_jaddr + 1) % DEPTH;
        check_eq("write_busy", lo, 1);
        check_state("write");
    endtask

    task automatic jtag_next();
        int lo;
        bus.jdo = rand_jdo();
        bus.take_no_action_ocimem_a = 1'b1;
        tick();
        bus.take_no_action_ocimem_a = 1'b0;
        wait_ready(lo);
        m_mon   = m_mem[m_jaddr];
        m_jaddr = (m_jaddr + 1) % DEPTH;
        check_eq("next_busy", lo, 2);
        check_state("next");
    endtask

    task automatic cpu_write(input logic [7:0] addr, input logic [31:0] data);
        bus.cpu_address   = addr;
        bus.cpu_writedata = data;
        bus.cpu_write     = 1'b1;
        #1;
        check_eq("cpu_wr_wait", {31'b0, bus.cpu_waitrequest}, 32'd0);
        tick();
        bus.cpu_write = 1'b0;
        m_mem[addr] = data;
    endtask

    // Called in the cycle the read is accepted (waitrequest low, cpu_read high).
    task automatic cpu_finish_read(input logic [7:0] addr);
        int lat;
        tick();
        bus.cpu_read = 1'b0;
        lat = 1;
        while (bus.cpu_readdatavalid !== 1'b1 && lat < 8) begin
            tick();
            lat++;
        end
        check_eq("cpu_rd_lat", lat, 2);
        check_eq("cpu_rd_data", bus.cpu_readdata, m_mem[addr]);
        tick();
        check_eq("cpu_rd_pulse", {31'b0, bus.cpu_readdatavalid}, 32'd0);
    endtask

    task automatic cpu_read(input logic [7:0] addr);
        int stall;
        bus.cpu_address = addr;
        bus.cpu_read    = 1'b1;
        #1;
        stall = 0;
        while (bus.cpu_waitrequest && stall < 16) begin
            stall++;
            tick();
        end
        check_eq("cpu_rd_stall", stall, 0);
        cpu_finish_read(addr);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", failures);
        $fatal(1);
    end

    initial begin
        logic [37:0] j;
        int lo;
        int stall;

        reset = 1'b1;
        bus.jdo = '0;
        bus.take_action_ocimem_a = 1'b0;
        bus.take_action_ocimem_b = 1'b0;
        bus.take_no_action_ocimem_a = 1'b0;
        bus.cpu_address = '0;
        bus.cpu_read = 1'b0;
        bus.cpu_write = 1'b0;
        bus.cpu_writedata = '0;
        tick();
        tick();
        check_eq("rst_mon",   bus.MonDReg, 32'd0);
        check_eq("rst_ready", {31'b0, bus.monitor_ready}, 32'd1);
        check_eq("rst_err",   {31'b0, bus.monitor_error}, 32'd0);
        check_eq("rst_rdata", bus.cpu_readdata, 32'd0);
        check_eq("rst_rvld",  {31'b0, bus.cpu_readdatavalid}, 32'd0);
        check_eq("rst_wait",  {31'b0, bus.cpu_waitrequest}, 32'd0);
        reset = 1'b0;
        tick();
        m_mon = '0;
        m_err = 1'b0;
        m_jaddr = 0;

        // Give every RAM word a known value through the CPU port (protected region included).
        for (int i = 0; i < DEPTH; i++) begin
            cpu_write(8'(i), $urandom);
        end

        // Basic JTAG write then read back.
        jtag_load(8'h40, 1'b0, 1'b0);
        jtag_write(32'hDEADBEEF);
        jtag_load(8'h40, 1'b1, 1'b0);
        jtag_next();
        cpu_read(8'h40);

        // Protected region: write rejected, next load clears the flag.
        jtag_load(8'h05, 1'b0, 1'b0);
        jtag_write(32'h12345678);
        jtag_load(8'h05, 1'b1, 1'b0);

        // Protection boundary: last protected word then first writable one.
        jtag_load(8'h1F, 1'b0, 1'b0);
        jtag_write(32'hA5A5_0001);
        jtag_write(32'hA5A5_0002);
        jtag_load(8'h1F, 1'b1, 1'b0);
        jtag_next();

        // Address wrap into the protected region.
        jtag_load(8'hFF, 1'b0, 1'b0);
        jtag_write(32'h1);
        jtag_write(32'h2);
        jtag_next();
        jtag_load(8'hFF, 1'b1, 1'b0);
        jtag_next();

        // Simultaneous ocimem_a and ocimem_b: a taken, b flagged and not written.
        jtag_load(8'h50, 1'b0, 1'b1);
        jtag_load(8'h50, 1'b1, 1'b0);

        // CPU read stalled behind a JTAG read presented in the same cycle.
        jtag_load(8'h3F, 1'b0, 1'b0);
        bus.cpu_address = 8'h40;
        bus.cpu_read = 1'b1;
        bus.take_no_action_ocimem_a = 1'b1;
        #1;
        check_eq("conc_wait0", {31'b0, bus.cpu_waitrequest}, 32'd1);
        tick();
        bus.take_no_action_ocimem_a = 1'b0;
        stall = 1;
        while (bus.cpu_waitrequest && stall < 16) begin
            stall++;
            tick();
        end
        m_mon = m_mem[m_jaddr];
        m_jaddr = (m_jaddr + 1) % DEPTH;
        check_eq("conc_stall", stall, 3);
        check_state("conc");
        cpu_finish_read(8'h40);

        // Collision: ocimem_b during JRD is dropped.
        j = rand_jdo();
        j[35] = 1'b1;
        j[24:17] = 8'h60;
        bus.jdo = j;
        bus.take_action_ocimem_a = 1'b1;
        tick();
        bus.take_action_ocimem_a = 1'b0;
        j = rand_jdo();
        j[34:3] = 32'hCAFEF00D;
        bus.jdo = j;
        bus.take_action_ocimem_b = 1'b1;
        tick();
        bus.take_action_ocimem_b = 1'b0;
        wait_ready(lo);
        m_mon = m_mem[8'h60];
        m_jaddr = 8'h61;
        m_err = 1'b1;
        check_eq("coll_busy", lo, 1);
        check_state("coll");
        jtag_next();

        // Reset during JRD: outputs return to reset values without a clock edge.
        j = rand_jdo();
        j[35] = 1'b1;
        j[24:17] = 8'h70;
        bus.jdo = j;
        bus.take_action_ocimem_a = 1'b1;
        tick();
        bus.take_action_ocimem_a = 1'b0;
        reset = 1'b1;
        #1;
        check_eq("arst_mon",   bus.MonDReg, 32'd0);
        check_eq("arst_ready", {31'b0, bus.monitor_ready}, 32'd1);
        check_eq("arst_err",   {31'b0, bus.monitor_error}, 32'd0);
        check_eq("arst_wait",  {31'b0, bus.cpu_waitrequest}, 32'd0);
        #1;
        reset = 1'b0;
        tick();
        m_mon = '0;
        m_err = 1'b0;
        m_jaddr = 0;
        jtag_next();

        // Randomized mix of operations against the model.
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 6))
                0: jtag_load(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
                1: jtag_write($urandom);
                2: jtag_next();
                3: cpu_write(8'($urandom_range(0, 255)), $urandom);
                4: cpu_read(8'($urandom_range(0, 255)));
                5: jtag_load(8'($urandom_range(0, 40)), 1'b0, 1'b0);
                default: jtag_load(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
